// File: rtl/sum_sq_bcd_conv_pkg.sv
// ============================================================================
// Package : sum_sq_pkg
// Shared defaults, FSM state type and 7-segment codes for sum_sq_bcd_conv.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sum_sq_pkg;

   localparam int SUM_SQ_IN_W   = 11;
   localparam int SUM_SQ_DIGITS = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Segment bit order: bit0 = a ... bit6 = g, active high.
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   function automatic logic [6:0] seg_of(input logic [3:0] digit);
      logic [6:0] code;
      case (digit)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sum_sq_bcd_conv_add3.sv
// ============================================================================
// Module  : bcd_add3_nibble
// Double-dabble correction for one BCD digit: values of 5 or more get +3.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_add3_nibble (
   input  logic [3:0] i_nib,
   output logic [3:0] o_nib
);

   assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

`default_nettype wire

// File: rtl/sum_sq_bcd_conv.sv
// ============================================================================
// Module  : sum_sq_bcd_conv
// Bit-serial binary-to-BCD (double-dabble) converter with valid/ready on both
// sides. Optional 7-segment output enabled by SUM_SQ_BCD_SEVSEG_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_sq_bcd_conv
   import sum_sq_pkg::*;
#(
   parameter int IN_W   = SUM_SQ_IN_W,
   parameter int DIGITS = SUM_SQ_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_W-1:0]       in_bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  busy
`ifdef SUM_SQ_BCD_SEVSEG_EN
   ,
   output logic [7*DIGITS-1:0]   seg
`endif
);

   localparam int CNT_W = $clog2(IN_W + 1);
   localparam int BCD_W = 4 * DIGITS;

   if (10 ** DIGITS <= (2 ** IN_W) - 1) begin : g_bad_digits
      $error("sum_sq_bcd_conv: DIGITS=%0d too small for IN_W=%0d", DIGITS, IN_W);
   end

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IN_W-1:0]       r_bin;
   logic [BCD_W-1:0]      r_bcd;
   logic [BCD_W-1:0]      r_out_bcd;
   logic [CNT_W-1:0]      r_cnt;
   logic [BCD_W-1:0]      w_bcd_adj;
   logic [BCD_W+IN_W-1:0] w_comb_shf;
   logic [BCD_W-1:0]      w_bcd_shf;
   logic [IN_W-1:0]       w_bin_shf;
   logic                  w_last;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3_nibble u_add3 (
         .i_nib (r_bcd[4*g +: 4]),
         .o_nib (w_bcd_adj[4*g +: 4])
      );
   end

   // The DIGITS constraint guarantees the top adjusted bit is zero, so
   // dropping it in the shift loses nothing.
   assign w_comb_shf = {w_bcd_adj, r_bin} << 1;
   assign w_bcd_shf  = w_comb_shf[BCD_W+IN_W-1:IN_W];
   assign w_bin_shf  = w_comb_shf[IN_W-1:0];
   assign w_last     = (r_cnt == CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bin     <= '0;
         r_bcd     <= '0;
         r_cnt     <= '0;
         r_out_bcd <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_bin <= in_bin;
                  r_bcd <= '0;
                  r_cnt <= CNT_W'(IN_W);
               end
            end
            ST_SHIFT: begin
               r_bcd <= w_bcd_shf;
               r_bin <= w_bin_shf;
               r_cnt <= r_cnt - CNT_W'(1);
               if (w_last) begin
                  r_out_bcd <= w_bcd_shf;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign out_bcd = r_out_bcd;

`ifdef SUM_SQ_BCD_SEVSEG_EN
   logic w_lead_zero;

   // Scan from the most significant digit; blank until the first non-zero
   // digit, and never blank the units digit.
   always_comb begin
      seg         = '0;
      w_lead_zero = 1'b1;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         if ((r_out_bcd[4*d +: 4] != 4'd0) || (d == 0)) begin
            w_lead_zero = 1'b0;
         end
         seg[7*d +: 7] = w_lead_zero ? SEG_BLANK : seg_of(r_out_bcd[4*d +: 4]);
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sum_sq_bcd_conv.sv
// ============================================================================
// Module  : tb_sum_sq_bcd_conv
// Self-checking bench for sum_sq_bcd_conv with a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sum_sq_bcd_conv;

   localparam int IN_W   = 11;
   localparam int DIGITS = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic [IN_W-1:0]   in_bin = '0;
   wire               in_ready;
   wire               out_valid;
   wire               busy;
   wire  [15:0]       out_bcd;
`ifdef SUM_SQ_BCD_SEVSEG_EN
   wire  [27:0]       seg;
`endif

   sum_sq_bcd_conv #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bin    (in_bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
      .busy      (busy)
`ifdef SUM_SQ_BCD_SEVSEG_EN
      ,
      .seg       (seg)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int          x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Transaction model: phase 0 idle, 1 converting, 2 holding result.
   int          m_phase = 0;
   int          m_left  = 0;
   int          m_val   = 0;
   logic [15:0] m_bcd   = '0;
   int          accept_q[$];
   logic [15:0] got_q[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0;
         m_left  = 0;
         m_val   = 0;
         m_bcd   = '0;
      end else begin
         cyc++;
         case (m_phase)
            0: if (in_valid) begin
                  m_val   = int'(in_bin);
                  m_left  = IN_W;
                  m_phase = 1;
                  accept_q.push_back(cyc);
               end
            1: begin
                  m_left--;
                  if (m_left == 0) begin
                     m_bcd   = to_bcd(m_val);
                     m_phase = 2;
                  end
               end
            default: if (out_ready) m_phase = 0;
         endcase
      end
   end

`ifdef SUM_SQ_BCD_SEVSEG_EN
   logic [6:0] segt [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   function automatic logic [27:0] exp_seg(input int v);
      logic [27:0] s;
      int          x;
      s = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (i == 0 || x != 0) s[7*i +: 7] = segt[x % 10];
         x = x / 10;
      end
      return s;
   endfunction
`endif

   always @(negedge clk) begin
      if (!rst) begin
         check("in_ready",  32'(in_ready),  32'(m_phase == 0));
         check("busy",      32'(busy),      32'(m_phase == 1));
         check("out_valid", 32'(out_valid), 32'(m_phase == 2));
         check("out_bcd",   32'(out_bcd),   32'(m_bcd));
`ifdef SUM_SQ_BCD_SEVSEG_EN
         check("seg", 32'(seg), 32'(exp_seg(
            (m_bcd[15:12] * 1000) + (m_bcd[11:8] * 100) + (m_bcd[7:4] * 10) + m_bcd[3:0])));
`endif
         if (out_valid && out_ready) got_q.push_back(out_bcd);
      end
   end

   task automatic convert(input int v, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b1;
      in_bin   = IN_W'(v);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int a0;
      int n;

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_out_bcd",   32'(out_bcd),   32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Single conversion and latency.
      out_ready = 1'b1;
      @(posedge clk); #1;
      convert(5, lat);
      check("latency_5", 32'(lat), 32'd11);
      check("bcd_5", 32'(out_bcd), 32'h0005);
`ifdef SUM_SQ_BCD_SEVSEG_EN
      check("seg_5", 32'(seg), {4'h0, 7'h00, 7'h00, 7'h00, 7'h6D});
`endif
      @(posedge clk); #1;

      // Back-to-back with in_valid held high.
      a0 = accept_q.size();
      in_valid = 1'b1;
      in_bin   = IN_W'(30);
      n = 0;
      while (accept_q.size() <= a0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      in_bin = IN_W'(1240);
      n = 0;
      while (accept_q.size() <= a0 + 1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      if (accept_q.size() > a0 + 1) begin
         check("accept_spacing", 32'(accept_q[a0+1] - accept_q[a0]), 32'd13);
      end else begin
         check("accept_timeout", 32'(accept_q.size()), 32'(a0 + 2));
      end
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(negedge clk); #1;
      check("got_count_b2b", 32'(got_q.size()), 32'd3);
      if (got_q.size() >= 3) begin
         check("bcd_30",   32'(got_q[1]), 32'h0030);
         check("bcd_1240", 32'(got_q[2]), 32'h1240);
      end
`ifdef SUM_SQ_BCD_SEVSEG_EN
      check("seg_1240", 32'(seg), {4'h0, 7'h06, 7'h5B, 7'h66, 7'h3F});
`endif
      @(posedge clk); #1;

      // Corner values.
      convert(0, lat);
      check("bcd_0", 32'(out_bcd), 32'h0000);
      @(posedge clk); #1;
      convert(2047, lat);
      check("bcd_2047", 32'(out_bcd), 32'h2047);
      @(posedge clk); #1;

      // Backpressure while holding 1240.
      out_ready = 1'b0;
      convert(1240, lat);
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_bin   = IN_W'($urandom_range(0, 2047));
         @(posedge clk); #1;
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_bcd",   32'(out_bcd),   32'h1240);
         check("hold_ready", 32'(in_ready),  32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_valid", 32'(out_valid), 32'd0);
      check("release_ready", 32'(in_ready),  32'd1);

      // Asynchronous reset mid-conversion.
      in_valid = 1'b1;
      in_bin   = IN_W'(2047);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_busy",      32'(busy),      32'd0);
      check("arst_in_ready",  32'(in_ready),  32'd1);
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_bcd",   32'(out_bcd),   32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      convert(14, lat);
      check("bcd_14", 32'(out_bcd), 32'h0014);
      check("latency_14", 32'(lat), 32'd11);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 7))
            0:       in_bin = '0;
            1:       in_bin = '1;
            default: in_bin = IN_W'($urandom_range(0, 2047));
         endcase
         out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, limit 500000 reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
